// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: op codes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_SLL    = 5'b00010,
    OP_SLT    = 5'b00011,
    OP_SRA    = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SLTU   = 5'b00111,
    OP_OR     = 5'b01000,
    OP_AND    = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle of the ALU / mul-div unit; the producer/consumer side uses master.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            Z;
  logic            N;
  logic            V;
  logic            C;

  modport master (
    output flush, in_valid, op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, Z, N, V, C
  );

  modport slave (
    input  flush, in_valid, op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, Z, N, V, C
  );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative multiply (shift-add) and restoring divide on operand magnitudes, one step per cycle.
// done is raised in the XLEN-th step cycle with the signed-corrected result already on result.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              active_q, active_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic              is_div, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic [XLEN:0]     partial;

  assign is_div = op[2];
  assign a_neg  = a[XLEN-1] && (is_div ? !op[0] : (op[1:0] != 2'b11));
  assign b_neg  = b[XLEN-1] && (is_div ? !op[0] : !op[1]);
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // Divide keeps {remainder, quotient} in acc; multiply keeps {high partial, multiplier}.
  always_comb begin
    partial  = '0;
    acc_step = acc_q;
    if (op_q[2]) begin
      partial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
      if (!partial[XLEN]) acc_step = {partial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      partial  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      acc_step = {partial, acc_q[XLEN-1:1]};
    end
  end

  assign done = active_q && (cnt_q == LAST);
  assign prod = neg_quo_q ? -acc_step : acc_step;
  assign quo  = neg_quo_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
  assign rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      default:                result = op_q[1] ? rem : quo;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    active_d  = active_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (active_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 1'b1;
      if (done) active_d = 1'b0;
    end
    if (start) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      op_d      = op;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      acc_d     = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd_d    = is_div ? b_mag : a_mag;
    end
    if (flush) active_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      active_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      active_q  <= active_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with an iterative multiply/divide unit behind a valid/ready handshake.
// ALU ops, undefined ops and the divide special cases finish in one cycle; the rest use seq_muldiv.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic        clk,
  input  logic        rst,
  alu_muldiv_if.slave bus
);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  flags_t          flags_q, flags_d;

  logic [4:0]      op;
  logic [XLEN-1:0] a, b, b_eff, fast_res, md_res;
  logic [XLEN:0]   sum;
  logic [SHW-1:0]  shamt;
  logic            cout, ovf, fast_c, fast_v, is_fast, accept, md_start, md_done;

  assign op    = bus.op;
  assign a     = bus.operand_a;
  assign b     = bus.operand_b;
  assign shamt = b[SHW-1:0];
  assign b_eff = op[0] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, op[0]};
  assign cout  = sum[XLEN];
  assign ovf   = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

  // slt/sltu share the subtract path since their op codes have op[0] set.
  always_comb begin
    fast_res = '0;
    fast_c   = 1'b0;
    fast_v   = 1'b0;
    is_fast  = 1'b1;
    case (op)
      OP_ADD, OP_SUB: begin
        fast_res = sum[XLEN-1:0];
        fast_c   = cout;
        fast_v   = ovf;
      end
      OP_SLL:  fast_res = a << shamt;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, sum[XLEN-1]};
      OP_SRA:  fast_res = $signed(a) >>> shamt;
      OP_XOR:  fast_res = a ^ b;
      OP_SRL:  fast_res = a >> shamt;
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, ~cout};
      OP_OR:   fast_res = a | b;
      OP_AND:  fast_res = a & b;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_fast = 1'b0;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (b == '0)                                fast_res = op[1] ? a : '1;
        else if (!op[0] && a == SMIN && b == '1)    fast_res = op[1] ? '0 : SMIN;
        else                                        is_fast  = 1'b0;
      end
      default: fast_res = '0;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.Z         = flags_q.z;
  assign bus.N         = flags_q.n;
  assign bus.V         = flags_q.v;
  assign bus.C         = flags_q.c;
  assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
  assign md_start      = accept && !is_fast;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_fast) begin
            state_d   = S_DONE;
            result_d  = fast_res;
            flags_d.z = (fast_res == '0);
            flags_d.n = fast_res[XLEN-1];
            flags_d.v = fast_v;
            flags_d.c = fast_c;
          end else begin
            state_d = S_BUSY;
          end
        end else if (state_q == S_DONE && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (md_done) begin
          state_d   = S_DONE;
          result_d  = md_res;
          flags_d.z = (md_res == '0);
          flags_d.n = md_res[XLEN-1];
          flags_d.v = 1'b0;
          flags_d.c = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= flags_t'(4'b1000);
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  seq_muldiv #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (bus.flush),
    .start  (md_start),
    .op     (op[2:0]),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_res)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written handshake/flush/reset sequences.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_muldiv_if #(.XLEN(32)) bus ();

  alu_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Behavioural model: results straight from integer arithmetic on the operands.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f, output int lat);
    longint      sa, sb, q;
    logic [63:0] w;
    logic        c, v;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      5'b00000: begin w = {32'b0, a} + {32'b0, b}; r = w[31:0]; c = w[32]; q = sa + sb; v = (q > SMAX) || (q < SMIN); end
      5'b00001: begin r = a - b; c = (a >= b); q = sa - sb; v = (q > SMAX) || (q < SMIN); end
      5'b00010: r = a << b[4:0];
      5'b00011: begin w = {32'b0, a - b}; r = {31'b0, w[31]}; end
      5'b00100: r = $signed(a) >>> b[4:0];
      5'b00101: r = a ^ b;
      5'b00110: r = a >> b[4:0];
      5'b00111: r = (a < b) ? 32'd1 : 32'd0;
      5'b01000: r = a | b;
      5'b01001: r = a & b;
      5'b10000: begin w = 64'(sa * sb); r = w[31:0]; lat = 33; end
      5'b10001: begin w = 64'(sa * sb); r = w[63:32]; lat = 33; end
      5'b10010: begin w = 64'(sa * longint'({32'b0, b})); r = w[63:32]; lat = 33; end
      5'b10011: begin w = {32'b0, a} * {32'b0, b}; r = w[63:32]; lat = 33; end
      5'b10100, 5'b10110: begin
        if (b == 32'd0)                                r = op[1] ? a : 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = op[1] ? 32'd0 : 32'h80000000;
        else begin
          q   = op[1] ? (sa % sb) : (sa / sb);
          r   = q[31:0];
          lat = 33;
        end
      end
      5'b10101, 5'b10111: begin
        if (b == 32'd0) r = op[1] ? a : 32'hFFFFFFFF;
        else begin
          r   = op[1] ? (a % b) : (a / b);
          lat = 33;
        end
      end
      default: r = '0;
    endcase
    f = {(r == 32'd0), r[31], v, c};
  endfunction

  // Issues one op from IDLE, waits (bounded) for the result, then retires it.
  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] flg, output int lat);
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.op        = 5'($urandom);
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    flg = {bus.Z, bus.N, bus.V, bus.C};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[18];
  logic [4:0]  codes[18];
  logic [4:0]  bb_op[4];
  logic [31:0] bb_a[4];
  logic [31:0] bb_b[4];

  initial begin
    logic [31:0] res, exp_res;
    logic [3:0]  flg, exp_flg;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int          lat, exp_lat, seen;

    tbl[0]  = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1};
    tbl[1]  = '{5'b00001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1001, 1};
    tbl[2]  = '{5'b00100, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b0100, 1};
    tbl[3]  = '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33};
    tbl[4]  = '{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33};
    tbl[5]  = '{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100, 33};
    tbl[6]  = '{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 33};
    tbl[7]  = '{5'b10101, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 1};
    tbl[8]  = '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 1};
    tbl[9]  = '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 1};
    tbl[10] = '{5'b01111, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 4'b1000, 1};
    tbl[11] = '{5'b00011, 32'h80000000, 32'h00000001, 32'h00000000, 4'b1000, 1};
    tbl[12] = '{5'b00111, 32'h00000001, 32'h00000002, 32'h00000001, 4'b0000, 1};
    tbl[13] = '{5'b10111, 32'h00001234, 32'h00000000, 32'h00001234, 4'b0000, 1};
    tbl[14] = '{5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 33};
    tbl[15] = '{5'b00010, 32'h00000001, 32'h00000025, 32'h00000020, 4'b0000, 1};
    tbl[16] = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001, 1};
    tbl[17] = '{5'b10000, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 33};

    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
              5'b01001, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_output("reset state", {bus.out_valid, bus.in_ready, bus.result, bus.Z, bus.N, bus.V, bus.C},
                 {1'b0, 1'b1, 32'd0, 4'b1000});

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i].op, tbl[i].a, tbl[i].b, res, flg, lat);
      check_output($sformatf("tbl[%0d] result", i), 64'(res), 64'(tbl[i].res));
      check_output($sformatf("tbl[%0d] flags ZNVC", i), 64'(flg), 64'(tbl[i].flg));
      check_output($sformatf("tbl[%0d] latency", i), 64'(lat), 64'(tbl[i].lat));
    end

    for (int i = 0; i < 120; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 17)];
      ra  = pick_operand();
      rb  = pick_operand();
      ref_model(rop, ra, rb, exp_res, exp_flg, exp_lat);
      apply_stimulus(rop, ra, rb, res, flg, lat);
      check_output($sformatf("rand[%0d] op=%b a=%h b=%h result", i, rop, ra, rb), 64'(res), 64'(exp_res));
      check_output($sformatf("rand[%0d] flags ZNVC", i), 64'(flg), 64'(exp_flg));
      check_output($sformatf("rand[%0d] latency", i), 64'(lat), 64'(exp_lat));
    end

    // Backpressure: result held while the consumer stalls; offered inputs must be ignored.
    bus.op = 5'b00000; bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.op = 5'b01000; bus.operand_a = 32'hF00; bus.operand_b = 32'h0FF;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("stall[%0d] valid/ready/result", k), {bus.out_valid, bus.in_ready, bus.result},
                   {1'b1, 1'b0, 32'd7});
      @(posedge clk); #1;
    end

    bb_op = '{5'b00000, 5'b00101, 5'b00010, 5'b00001};
    bb_a  = '{32'd1, 32'hF0, 32'd1, 32'd3};
    bb_b  = '{32'd2, 32'hFF, 32'd4, 32'd5};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.op = bb_op[k]; bus.operand_a = bb_a[k]; bus.operand_b = bb_b[k];
      @(posedge clk); #1;
      ref_model(bb_op[k], bb_a[k], bb_b[k], exp_res, exp_flg, exp_lat);
      check_output($sformatf("b2b[%0d] valid/ready/result", k), {bus.out_valid, bus.in_ready, bus.result},
                   {1'b1, 1'b1, exp_res});
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_output("b2b drain out_valid", 64'(bus.out_valid), 64'd0);

    // Flush in BUSY cycle 10 of a multiply.
    bus.op = 5'b10000; bus.operand_a = 32'd1234; bus.operand_b = 32'd5678; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_output("flush busy valid/ready", {bus.out_valid, bus.in_ready}, 2'b01);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_output("flush busy later out_valid", 64'(seen), 64'd0);
    apply_stimulus(5'b10000, 32'd1234, 32'd5678, res, flg, lat);
    check_output("after flush mul result", 64'(res), 64'd7006652);

    // Flush beats a simultaneous input handshake.
    bus.op = 5'b00000; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check_output("flush drops input valid/ready", {bus.out_valid, bus.in_ready}, 2'b01);
    @(posedge clk); #1;
    check_output("flush drops input later", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset in the middle of a divide.
    bus.op = 5'b10101; bus.operand_a = 32'd1000; bus.operand_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    check_output("rst busy state", {bus.out_valid, bus.in_ready, bus.result, bus.Z, bus.N, bus.V, bus.C},
                 {1'b0, 1'b1, 32'd0, 4'b1000});
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_output("rst busy later out_valid", 64'(seen), 64'd0);
    apply_stimulus(5'b10101, 32'd1000, 32'd7, res, flg, lat);
    check_output("after rst divu result", 64'(res), 64'd142);
    check_output("after rst divu latency", 64'(lat), 64'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning datapath width; legal values 8, 16, 32, 64.
REQ-002 The module SHALL have parameter SHW, default $clog2(XLEN), meaning shift-amount width; derived, not overridden.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port flush  input  1  synchronous abort of any accepted, unreturned operation.
REQ-006 The module SHALL have port in_valid  input  1  operation offered.
REQ-007 The module SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-008 The module SHALL have port op  input  5  operation code; op[4]=0 selects ALU ops, op[4]=1 selects mul/div ops.
REQ-009 The module SHALL have ports operand_a and operand_b  input  XLEN  source operands.
REQ-010 The module SHALL have port out_valid  output  1  result available.
REQ-011 The module SHALL have port out_ready  input  1  consumer takes the result when out_valid && out_ready.
REQ-012 The module SHALL have port result  output  XLEN  registered result.
REQ-013 The module SHALL have ports Z, N, V and C  output  1 each  registered flags for result.

Function
REQ-014 ALU codes SHALL be: 00000 add, 00001 sub, 00010 sll, 00011 slt, 00100 sra, 00101 xor, 00110 srl, 00111 sltu, 01000 or, 01001 and.
REQ-015 Mul/div codes SHALL be: 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu; other codes are undefined.
REQ-016 Shifts SHALL use operand_b[SHW-1:0] only; sra SHALL sign-fill from operand_a[XLEN-1].
REQ-017 Add/sub SHALL compute operand_a + (op[0] ? ~operand_b : operand_b) + op[0] with carry-out cout.
REQ-018 Compare results SHALL be zero-extended to XLEN: slt = sum MSB (no overflow correction), sltu = ~cout.
REQ-019 Z SHALL be (result == 0) and N SHALL be result[XLEN-1], for every op.
REQ-020 C SHALL equal cout for add/sub, else 0.
REQ-021 V SHALL equal signed overflow of the add/sub for add/sub, else 0.
REQ-022 An undefined op SHALL complete in 1 cycle with result 0, Z=1 and N=V=C=0.
REQ-023 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-024 IDLE: in_ready=1 and out_valid=0; accepting an ALU or undefined op SHALL go to DONE with the result registered, giving 1-cycle latency.
REQ-025 IDLE: accepting a mul/div op SHALL latch the operands and go to BUSY.
REQ-026 BUSY SHALL last exactly XLEN cycles using one shift-add (mul) or restoring (div) step per cycle, then go to DONE; in_ready=0 during BUSY.
REQ-027 mul SHALL return the low XLEN bits of the 2*XLEN product; mulh, mulhsu and mulhu SHALL return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-028 Signed divide SHALL operate on magnitudes and apply the sign at completion: quotient truncates toward zero, remainder takes the sign of the dividend.
REQ-029 Divide by zero SHALL complete in 1 cycle (IDLE->DONE) with quotient = all ones and remainder = operand_a.
REQ-030 Signed overflow (div/rem of most-negative value by -1) SHALL complete in 1 cycle with quotient = most-negative value and remainder = 0.
REQ-031 DONE: out_valid=1, and result/flags SHALL be held stable until out_ready.
REQ-032 DONE: in_ready SHALL equal out_ready; handshakes on both sides in the same cycle SHALL retire the old result and start the new op with no bubble.
REQ-033 DONE: out_ready without a new input SHALL return the FSM to IDLE.
REQ-034 Inputs SHALL be ignored when in_ready=0; operands and op need not be held after acceptance.
REQ-035 flush SHALL force IDLE on the next edge from any state, discarding any result; out_valid=0 and in_ready=1 on the following cycle.
REQ-036 flush SHALL take priority over a simultaneous input handshake, which is dropped.

Reset
REQ-037 rst SHALL asynchronously force state=IDLE, result=0, Z=1, N=V=C=0, out_valid=0 and the iteration counter to 0; in_ready=1 while in IDLE.
REQ-038 rst asserted mid-BUSY SHALL abort the operation with no result ever presented.

Structure
REQ-039 Package alu_pkg SHALL hold the op enum (5-bit) and the FSM state enum.
REQ-040 Sub-module seq_muldiv SHALL hold the iterative multiply/divide datapath and counter, with start/done signals toward the parent FSM.
REQ-041 ALU ops SHALL be implemented combinationally in the parent, using operator shifts rather than per-amount mux chains.

Verification
REQ-042 add: XLEN=32, a=0x7FFFFFFF, b=1 -> after 1 cycle result 0x80000000, N=1, V=1, C=0, Z=0.
REQ-043 sub: a=5, b=5 -> result 0, Z=1, C=1, V=0; sra: a=0x80000000, b=31 -> result 0xFFFFFFFF.
REQ-044 mulh: a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0 with out_valid exactly 33 cycles after acceptance; mulhu with the same operands -> result 0xFFFFFFFE.
REQ-045 div: a=-7, b=2 -> result -3; rem -> result -1; divu with b=0 -> result 0xFFFFFFFF after 1 cycle; div with a=0x80000000, b=-1 -> result 0x80000000.
REQ-046 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0; then back-to-back ALU ops with out_ready=1 -> one result per cycle.
REQ-047 flush at BUSY cycle 10, and separately rst mid-BUSY -> out_valid never asserts for that op; the next op returns the correct result.
